motion_arbiter: RTL and testbench

MOTION_ARBITER -- requirements
Module: motion_arbiter

---
 rtl/motion_arbiter.sv | 180 ++++++++++++++++++
 tb/tb_motion_arbiter.sv | 335 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/motion_arbiter.sv
// motion_arbiter
// Arbitrates manual (remote) and autonomous motion commands onto four
// registered direction strobes. Manual requests have strict priority.
// A direction reversal or turn inserts an all-off dead time before the new
// strobe is driven, and a forward move is aborted when an obstacle appears.
// One 16-bit down-counter times both the dead interval and the run interval.
module motion_arbiter #(
    parameter int unsigned DEAD_CYCLES = 4,
    parameter int unsigned RUN_CYCLES  = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       man_valid,
    input  logic [2:0] man_cmd,
    output logic       man_ready,
    input  logic       auto_valid,
    input  logic [2:0] auto_cmd,
    output logic       auto_ready,
    input  logic       obstacle,
    output logic       frente,
    output logic       tras,
    output logic       direita,
    output logic       esquerda,
    output logic       busy,
    output logic       last_src
);

    // Command encoding shared by both requesters.
    localparam logic [2:0] CMD_STOP     = 3'd0;
    localparam logic [2:0] CMD_FRENTE   = 3'd1;
    localparam logic [2:0] CMD_ESQUERDA = 3'd4;

    localparam logic [15:0] DEAD_LOAD = 16'(DEAD_CYCLES);
    localparam logic [15:0] RUN_LOAD  = 16'(RUN_CYCLES);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DEAD = 2'd1,
        ST_RUN  = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_state_next;
    logic [15:0] r_cnt;
    logic [15:0] w_cnt_next;
    logic [2:0]  r_cmd_q;
    logic [2:0]  w_cmd_q_next;
    logic [2:0]  r_last_dir;
    logic [2:0]  w_last_dir_next;
    logic        r_last_src;
    logic        w_last_src_next;
    logic [3:0]  r_strobe;       // {esquerda, direita, tras, frente}
    logic [3:0]  w_strobe_next;

    logic        w_idle;
    logic        w_man_hs;
    logic        w_auto_hs;
    logic        w_accept;
    logic [2:0]  w_grant_cmd;
    logic [2:0]  w_eff_cmd;
    logic        w_needs_dead;
    logic        w_abort;

    // One-hot strobe pattern for a movement code; stop and invalid give none.
    function automatic logic [3:0] dir_onehot(input logic [2:0] cmd);
        logic [3:0] pat;
        pat = 4'b0000;
        if (cmd != CMD_STOP && cmd <= CMD_ESQUERDA) begin
            pat[cmd - 3'd1] = 1'b1;
        end
        return pat;
    endfunction

    // Handshakes: only IDLE accepts, and auto only when manual is silent.
    assign w_idle      = (r_state == ST_IDLE);
    assign man_ready   = w_idle;
    assign auto_ready  = w_idle & ~man_valid;
    assign w_man_hs    = man_valid & man_ready;
    assign w_auto_hs   = auto_valid & auto_ready;
    assign w_accept    = w_man_hs | w_auto_hs;
    assign w_grant_cmd = w_man_hs ? man_cmd : auto_cmd;

    // Invalid codes and blocked forward moves collapse to stop.
    always_comb begin
        w_eff_cmd = w_grant_cmd;
        if (w_grant_cmd > CMD_ESQUERDA) begin
            w_eff_cmd = CMD_STOP;
        end else if (w_grant_cmd == CMD_FRENTE && obstacle) begin
            w_eff_cmd = CMD_STOP;
        end
    end

    // Dead time is only needed when switching between two different movements.
    assign w_needs_dead = (r_last_dir != CMD_STOP) && (r_last_dir != w_eff_cmd);
    assign w_abort      = (r_state == ST_RUN) && (r_cmd_q == CMD_FRENTE) && obstacle;

    // Next-state, counter and strobe logic; strobes are computed from the
    // state being entered so they register in step with RUN.
    always_comb begin
        w_state_next    = r_state;
        w_cnt_next      = r_cnt;
        w_cmd_q_next    = r_cmd_q;
        w_last_dir_next = r_last_dir;
        w_last_src_next = r_last_src;
        w_strobe_next   = 4'b0000;

        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_last_src_next = w_auto_hs;
                    w_cmd_q_next    = w_eff_cmd;
                    if (w_eff_cmd == CMD_STOP) begin
                        w_last_dir_next = CMD_STOP;
                    end else if (w_needs_dead) begin
                        w_state_next = ST_DEAD;
                        w_cnt_next   = DEAD_LOAD;
                    end else begin
                        w_state_next  = ST_RUN;
                        w_cnt_next    = RUN_LOAD;
                        w_strobe_next = dir_onehot(w_eff_cmd);
                    end
                end
            end
            ST_DEAD: begin
                if (r_cnt <= 16'd1) begin
                    w_state_next  = ST_RUN;
                    w_cnt_next    = RUN_LOAD;
                    w_strobe_next = dir_onehot(r_cmd_q);
                end else begin
                    w_cnt_next = r_cnt - 16'd1;
                end
            end
            ST_RUN: begin
                if (w_abort) begin
                    w_state_next    = ST_IDLE;
                    w_cnt_next      = 16'd0;
                    w_last_dir_next = CMD_STOP;
                end else if (r_cnt <= 16'd1) begin
                    w_state_next    = ST_IDLE;
                    w_cnt_next      = 16'd0;
                    w_last_dir_next = r_cmd_q;
                end else begin
                    w_cnt_next    = r_cnt - 16'd1;
                    w_strobe_next = dir_onehot(r_cmd_q);
                end
            end
            default: begin
                w_state_next = ST_IDLE;
                w_cnt_next   = 16'd0;
            end
        endcase
    end

    // State register; reset clears everything immediately, dropping strobes.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            r_cnt      <= 16'd0;
            r_cmd_q    <= CMD_STOP;
            r_last_dir <= CMD_STOP;
            r_last_src <= 1'b0;
            r_strobe   <= 4'b0000;
        end else begin
            r_state    <= w_state_next;
            r_cnt      <= w_cnt_next;
            r_cmd_q    <= w_cmd_q_next;
            r_last_dir <= w_last_dir_next;
            r_last_src <= w_last_src_next;
            r_strobe   <= w_strobe_next;
        end
    end

    assign frente   = r_strobe[0];
    assign tras     = r_strobe[1];
    assign direita  = r_strobe[2];
    assign esquerda = r_strobe[3];
    assign busy     = ~w_idle;
    assign last_src = r_last_src;

endmodule

// File: tb/tb_motion_arbiter.sv
// Bench for motion_arbiter: directed scenarios with explicit expected
// waveforms, then a randomized run checked against a queue-based model that
// turns each accepted command into its list of expected strobe cycles.
module tb_motion_arbiter;

    localparam int DEAD = 4;
    localparam int RUN  = 8;

    logic       clk = 1'b0;
    logic       reset;
    logic       man_valid;
    logic [2:0] man_cmd;
    logic       man_ready;
    logic       auto_valid;
    logic [2:0] auto_cmd;
    logic       auto_ready;
    logic       obstacle;
    logic       frente, tras, direita, esquerda;
    logic       busy;
    logic       last_src;
    logic [3:0] strobes;

    int n_cmp = 0;
    int n_bad = 0;

    assign strobes = {esquerda, direita, tras, frente};

    motion_arbiter #(
        .DEAD_CYCLES(DEAD),
        .RUN_CYCLES (RUN)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .man_valid (man_valid),
        .man_cmd   (man_cmd),
        .man_ready (man_ready),
        .auto_valid(auto_valid),
        .auto_cmd  (auto_cmd),
        .auto_ready(auto_ready),
        .obstacle  (obstacle),
        .frente    (frente),
        .tras      (tras),
        .direita   (direita),
        .esquerda  (esquerda),
        .busy      (busy),
        .last_src  (last_src)
    );

    always #5 clk = ~clk;

    // Advance one clock; tasks always resume just after a falling edge.
    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        reset = 1'b1; man_valid = 1'b0; auto_valid = 1'b0; obstacle = 1'b0;
        man_cmd = 3'd0; auto_cmd = 3'd0;
        cyc(); cyc();
        n_cmp++; if (strobes !== 4'b0000) begin n_bad++; $display("FAIL reset_strobes got %b want 0000", strobes); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy got %b want 0", busy); end
        n_cmp++; if (last_src !== 1'b0) begin n_bad++; $display("FAIL reset_last_src got %b want 0", last_src); end
        n_cmp++; if (man_ready !== 1'b1) begin n_bad++; $display("FAIL reset_man_ready got %b want 1", man_ready); end
        n_cmp++; if (auto_ready !== 1'b1) begin n_bad++; $display("FAIL reset_auto_ready got %b want 1", auto_ready); end
        man_valid = 1'b1;
        #1;
        n_cmp++; if (auto_ready !== 1'b0) begin n_bad++; $display("FAIL reset_auto_ready_man got %b want 0", auto_ready); end
        man_valid = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        cyc();
        $display("test_reset done");
    endtask

    // Forward move from rest: strobe for RUN cycles starting right after accept.
    task automatic test_frente();
        logic [3:0] want;
        man_valid = 1'b1; man_cmd = 3'd1;
        #1;
        n_cmp++; if (man_ready !== 1'b1) begin n_bad++; $display("FAIL frente_ready got %b want 1", man_ready); end
        cyc();
        man_valid = 1'b0;
        for (int k = 0; k < RUN + 2; k++) begin
            want = (k < RUN) ? 4'b0001 : 4'b0000;
            n_cmp++; if (strobes !== want) begin n_bad++; $display("FAIL frente_strobe[%0d] got %b want %b", k, strobes, want); end
            n_cmp++; if (busy !== (k < RUN)) begin n_bad++; $display("FAIL frente_busy[%0d] got %b want %b", k, busy, (k < RUN)); end
            cyc();
        end
        $display("test_frente done");
    endtask

    // Reversal from frente to tras by the auto source: dead time, then tras.
    task automatic test_dead_change();
        logic [3:0] want;
        auto_valid = 1'b1; auto_cmd = 3'd2;
        #1;
        n_cmp++; if (auto_ready !== 1'b1) begin n_bad++; $display("FAIL dead_auto_ready got %b want 1", auto_ready); end
        cyc();
        auto_valid = 1'b0;
        n_cmp++; if (last_src !== 1'b1) begin n_bad++; $display("FAIL dead_last_src got %b want 1", last_src); end
        for (int k = 0; k < DEAD + RUN + 1; k++) begin
            want = (k < DEAD) ? 4'b0000 : (k < DEAD + RUN) ? 4'b0010 : 4'b0000;
            n_cmp++; if (strobes !== want || busy !== (k < DEAD + RUN)) begin
                n_bad++; $display("FAIL dead_seq[%0d] got strobes=%b busy=%b want strobes=%b busy=%b", k, strobes, busy, want, (k < DEAD + RUN));
            end
            cyc();
        end
        $display("test_dead_change done");
    endtask

    // Simultaneous requests: manual wins; held auto request lands on first IDLE.
    task automatic test_priority();
        int wait_cycles;
        int n_fr;
        logic [3:0] want;
        man_valid = 1'b1; man_cmd = 3'd1; auto_valid = 1'b1; auto_cmd = 3'd3;
        #1;
        n_cmp++; if (auto_ready !== 1'b0) begin n_bad++; $display("FAIL prio_auto_ready got %b want 0", auto_ready); end
        n_cmp++; if (man_ready !== 1'b1) begin n_bad++; $display("FAIL prio_man_ready got %b want 1", man_ready); end
        cyc();
        man_valid = 1'b0;
        n_cmp++; if (last_src !== 1'b0) begin n_bad++; $display("FAIL prio_last_src got %b want 0", last_src); end
        wait_cycles = -1;
        n_fr = 0;
        for (int k = 0; k < 40; k++) begin
            if (auto_ready === 1'b1) begin
                wait_cycles = k;
                break;
            end
            if (frente === 1'b1) n_fr++;
            cyc();
        end
        n_cmp++; if (wait_cycles != DEAD + RUN) begin n_bad++; $display("FAIL prio_auto_wait got %0d want %0d", wait_cycles, DEAD + RUN); end
        n_cmp++; if (n_fr != RUN) begin n_bad++; $display("FAIL prio_frente_cycles got %0d want %0d", n_fr, RUN); end
        cyc();
        auto_valid = 1'b0;
        n_cmp++; if (last_src !== 1'b1) begin n_bad++; $display("FAIL prio_auto_src got %b want 1", last_src); end
        for (int k = 0; k < DEAD + RUN + 1; k++) begin
            want = (k < DEAD) ? 4'b0000 : (k < DEAD + RUN) ? 4'b0100 : 4'b0000;
            n_cmp++; if (strobes !== want) begin n_bad++; $display("FAIL prio_direita[%0d] got %b want %b", k, strobes, want); end
            cyc();
        end
        $display("test_priority done");
    endtask

    // Obstacle aborts frente; blocked frente is stop; next move skips dead time.
    task automatic test_obstacle();
        int got;
        int n_tr;
        man_valid = 1'b1; man_cmd = 3'd1; obstacle = 1'b0;
        cyc();
        man_valid = 1'b0;
        got = -1;
        for (int k = 0; k < 20; k++) begin
            if (frente === 1'b1) begin
                got = k;
                break;
            end
            cyc();
        end
        n_cmp++; if (got != DEAD) begin n_bad++; $display("FAIL obst_frente_start got %0d want %0d", got, DEAD); end
        cyc(); cyc();
        n_cmp++; if (frente !== 1'b1) begin n_bad++; $display("FAIL obst_frente_c3 got %b want 1", frente); end
        obstacle = 1'b1;
        cyc();
        n_cmp++; if (strobes !== 4'b0000 || busy !== 1'b0) begin n_bad++; $display("FAIL obst_abort got strobes=%b busy=%b want 0000/0", strobes, busy); end
        man_valid = 1'b1; man_cmd = 3'd1;
        cyc();
        man_valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            n_cmp++; if ({busy, strobes} !== 5'b0) begin n_bad++; $display("FAIL obst_blocked[%0d] got busy=%b strobes=%b want 0/0000", k, busy, strobes); end
            cyc();
        end
        obstacle = 1'b0;
        man_valid = 1'b1; man_cmd = 3'd2;
        cyc();
        man_valid = 1'b0;
        n_cmp++; if (strobes !== 4'b0010) begin n_bad++; $display("FAIL obst_tras_direct got %b want 0010", strobes); end
        n_tr = 0;
        for (int k = 0; k < RUN + 1; k++) begin
            if (tras === 1'b1) n_tr++;
            cyc();
        end
        n_cmp++; if (n_tr != RUN || busy !== 1'b0) begin n_bad++; $display("FAIL obst_tras_len got %0d busy=%b want %0d busy=0", n_tr, busy, RUN); end
        $display("test_obstacle done");
    endtask

    // Reset mid-RUN drops strobes without an edge; last_dir returns to stop.
    task automatic test_reset_mid_run();
        int got;
        man_valid = 1'b1; man_cmd = 3'd4;
        cyc();
        man_valid = 1'b0;
        got = -1;
        for (int k = 0; k < 20; k++) begin
            if (esquerda === 1'b1) begin
                got = k;
                break;
            end
            cyc();
        end
        n_cmp++; if (got != DEAD) begin n_bad++; $display("FAIL rst_esq_start got %0d want %0d", got, DEAD); end
        cyc(); cyc();
        #1 reset = 1'b1;
        #1;
        n_cmp++; if (strobes !== 4'b0000 || busy !== 1'b0) begin n_bad++; $display("FAIL rst_async got strobes=%b busy=%b want 0000/0", strobes, busy); end
        #1 reset = 1'b0;
        man_valid = 1'b1; man_cmd = 3'd3;
        @(posedge clk);
        @(negedge clk);
        man_valid = 1'b0;
        n_cmp++; if (strobes !== 4'b0100) begin n_bad++; $display("FAIL rst_direita_direct got %b want 0100", strobes); end
        n_cmp++; if (last_src !== 1'b0) begin n_bad++; $display("FAIL rst_last_src got %b want 0", last_src); end
        repeat (RUN + 1) cyc();
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL rst_run_out got busy=%b want 0", busy); end
        $display("test_reset_mid_run done");
    endtask

    // Invalid code acts as stop and clears last_dir, so a turn needs no dead time.
    task automatic test_invalid();
        man_valid = 1'b1; man_cmd = 3'd6;
        #1;
        n_cmp++; if (man_ready !== 1'b1) begin n_bad++; $display("FAIL inv_ready got %b want 1", man_ready); end
        cyc();
        man_valid = 1'b0;
        for (int k = 0; k < 2; k++) begin
            n_cmp++; if ({busy, strobes} !== 5'b0) begin n_bad++; $display("FAIL inv_idle[%0d] got busy=%b strobes=%b want 0/0000", k, busy, strobes); end
            cyc();
        end
        man_valid = 1'b1; man_cmd = 3'd4;
        cyc();
        man_valid = 1'b0;
        n_cmp++; if (strobes !== 4'b1000) begin n_bad++; $display("FAIL inv_esq_direct got %b want 1000", strobes); end
        repeat (RUN + 1) cyc();
        $display("test_invalid done");
    endtask

    // Held request, same direction: exactly one all-off cycle between runs.
    task automatic test_back_to_back();
        logic [3:0] want;
        man_valid = 1'b1; man_cmd = 3'd4;
        cyc();
        for (int k = 0; k < 2 * RUN + 1; k++) begin
            want = (k == RUN) ? 4'b0000 : 4'b1000;
            n_cmp++; if (strobes !== want) begin n_bad++; $display("FAIL b2b_strobe[%0d] got %b want %b", k, strobes, want); end
            if (k == RUN) begin
                n_cmp++; if (man_ready !== 1'b1) begin n_bad++; $display("FAIL b2b_gap_ready got %b want 1", man_ready); end
            end
            cyc();
        end
        man_valid = 1'b0;
        cyc();
        $display("test_back_to_back done");
    endtask

    // Random traffic against a queue model of expected strobe cycles.
    task automatic test_random();
        logic [3:0] exp_q[$];
        int         m_dir;
        int         m_cmd;
        logic       m_src;
        logic [3:0] exp_s;
        int         c;
        int         bad0;
        reset = 1'b1; man_valid = 1'b0; auto_valid = 1'b0; obstacle = 1'b0;
        cyc();
        reset = 1'b0;
        m_dir = 0; m_cmd = 0; m_src = 1'b0;
        bad0 = n_bad;
        for (int i = 0; i < 1500; i++) begin
            exp_s = (exp_q.size() != 0) ? exp_q[0] : 4'b0000;
            n_cmp++; if (strobes !== exp_s) begin n_bad++; $display("FAIL rnd_strobe[%0d] got %b want %b", i, strobes, exp_s); end
            n_cmp++; if (busy !== (exp_q.size() != 0)) begin n_bad++; $display("FAIL rnd_busy[%0d] got %b want %b", i, busy, (exp_q.size() != 0)); end
            n_cmp++; if (last_src !== m_src) begin n_bad++; $display("FAIL rnd_last_src[%0d] got %b want %b", i, last_src, m_src); end
            man_valid  = ($urandom % 5) == 0;
            man_cmd    = 3'($urandom % 8);
            auto_valid = ($urandom % 3) == 0;
            auto_cmd   = 3'($urandom % 8);
            obstacle   = ($urandom % 6) == 0;
            #1;
            n_cmp++; if (man_ready !== (exp_q.size() == 0)) begin n_bad++; $display("FAIL rnd_man_ready[%0d] got %b want %b", i, man_ready, (exp_q.size() == 0)); end
            n_cmp++; if (auto_ready !== (exp_q.size() == 0 && !man_valid)) begin n_bad++; $display("FAIL rnd_auto_ready[%0d] got %b want %b", i, auto_ready, (exp_q.size() == 0 && !man_valid)); end
            if (exp_q.size() == 0) begin
                if (man_valid || auto_valid) begin
                    m_src = !man_valid;
                    c = man_valid ? int'(man_cmd) : int'(auto_cmd);
                    if (c > 4 || (c == 1 && obstacle)) c = 0;
                    if (c == 0) begin
                        m_dir = 0;
                    end else begin
                        if (m_dir != 0 && m_dir != c) begin
                            repeat (DEAD) exp_q.push_back(4'b0000);
                        end
                        repeat (RUN) exp_q.push_back(4'(1 << (c - 1)));
                        m_cmd = c;
                    end
                end
            end else if (exp_q[0] == 4'b0001 && obstacle) begin
                exp_q.delete();
                m_dir = 0;
            end else begin
                void'(exp_q.pop_front());
                if (exp_q.size() == 0) m_dir = m_cmd;
            end
            cyc();
        end
        man_valid = 1'b0; auto_valid = 1'b0; obstacle = 1'b0;
        $display("test_random done, %0d new mismatches", n_bad - bad0);
    endtask

    initial begin
        reset = 1'b1; man_valid = 1'b0; auto_valid = 1'b0; obstacle = 1'b0;
        man_cmd = 3'd0; auto_cmd = 3'd0;
        @(negedge clk);
        test_reset();
        test_frente();
        test_dead_change();
        test_priority();
        test_obstacle();
        test_reset_mid_run();
        test_invalid();
        test_back_to_back();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

endmodule
